// File: rtl/divider_unit.sv
// Restoring shift-subtract divider: IDLE -> LOAD -> SHIFT x WIDTH -> DONE, one quotient bit per cycle.
// Optional DIVIDER_SIGNED_EN: two's-complement operands via magnitude divide plus result sign fix-up.
module divider_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int            CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    cnt;
  logic             dbz;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;
  logic             div_zero_in;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  assign last_iter   = (cnt == CW'(1));
  assign div_zero_in = (Divisor == '0);

  // One restoring step: shift {A,Q} left, trial-subtract M, restore on borrow.
  always_comb begin
    a_sh  = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    q_sh  = {q_reg[WIDTH-2:0], 1'b0};
    diff  = {1'b0, a_sh} - {2'b00, m_reg};
    a_nxt = a_sh;
    q_nxt = q_sh;
    if (!diff[WIDTH+1]) begin
      a_nxt = diff[WIDTH:0];
      q_nxt = {q_sh[WIDTH-1:1], 1'b1};
    end
  end

`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  assign dvd_mag = Dividend[WIDTH-1] ? (WIDTH'(0) - Dividend) : Dividend;
  assign dvs_mag = Divisor[WIDTH-1]  ? (WIDTH'(0) - Divisor)  : Divisor;
  assign quo_fin = neg_q ? (WIDTH'(0) - q_nxt) : q_nxt;
  assign rem_fin = neg_r ? (WIDTH'(0) - a_nxt[WIDTH-1:0]) : a_nxt[WIDTH-1:0];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == LOAD) begin
      neg_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
      neg_r <= Dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = Dividend;
  assign dvs_mag = Divisor;
  assign quo_fin = q_nxt;
  assign rem_fin = a_nxt[WIDTH-1:0];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Run) state_nxt = LOAD;
      LOAD:    state_nxt = div_zero_in ? DONE : SHIFT;
      SHIFT:   if (last_iter) state_nxt = DONE;
      DONE:    if (!Run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are written only on the edge that enters DONE.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      cnt       <= '0;
      dbz       <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          q_reg <= dvd_mag;
          m_reg <= dvs_mag;
          a_reg <= '0;
          cnt   <= ITERS;
          dbz   <= div_zero_in;
          if (div_zero_in) begin
            Quotient  <= '1;
            Remainder <= Dividend;
          end
        end
        SHIFT: begin
          a_reg <= a_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt - CW'(1);
          if (last_iter) begin
            Quotient  <= quo_fin;
            Remainder <= rem_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (state == LOAD) || (state == SHIFT);
  assign Done      = (state == DONE);
  assign DivByZero = Done && dbz;

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit (WIDTH=8): expected results queued at stimulus, popped at Done.
module tb_divider_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivByZero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  divider_unit #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] dvd, input logic [7:0] dvs);
    exp_t e;
`ifdef DIVIDER_SIGNED_EN
    int a, b;
`endif
    if (dvs == 8'd0) begin
      e.q = 8'hFF;
      e.r = dvd;
      e.z = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      a   = int'($signed(dvd));
      b   = int'($signed(dvs));
      e.q = 8'(a / b);
      e.r = 8'(a % b);
`else
      e.q = dvd / dvs;
      e.r = dvd % dvs;
`endif
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_div(input logic [7:0] dvd, input logic [7:0] dvs,
                         input bit toggle, input int hold);
    exp_t e;
    int   edges;
    int   lat;
    sb.push_back(model(dvd, dvs));
    lat      = (dvs == 8'd0) ? 2 : 10;
    Dividend = dvd;
    Divisor  = dvs;
    Run      = 1'b1;
    edges    = 0;
    do begin
      tick();
      edges++;
      if (toggle && edges >= 2 && !Done) begin
        Dividend = 8'($urandom);
        Divisor  = 8'($urandom);
        Run      = 1'($urandom_range(0, 1));
      end
    end while (!Done && edges < 40);
    check("latency", edges, lat);
    check("done", Done, 1);
    check("busy_in_done", Busy, 0);
    e = sb.pop_front();
    check("quotient", Quotient, e.q);
    check("remainder", Remainder, e.r);
    check("div_by_zero", DivByZero, e.z);
    Run = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("done_hold", Done, 1);
      check("busy_hold", Busy, 0);
    end
    Run = 1'b0;
    tick();
    check("done_clear", Done, 0);
    check("busy_idle", Busy, 0);
    check("quotient_held", Quotient, e.q);
  endtask

  initial begin
    Reset    = 1'b0;
    Run      = 1'b0;
    Dividend = 8'd0;
    Divisor  = 8'd0;
    repeat (3) tick();
    check("rst_quotient", Quotient, 0);
    check("rst_remainder", Remainder, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_dbz", DivByZero, 0);
    Reset = 1'b1;
    tick();

    run_div(8'd200, 8'd7, 1'b0, 0);
    run_div(8'd55, 8'd0, 1'b0, 0);
    run_div(8'd13, 8'd4, 1'b0, 5);
    repeat (2) begin
      tick();
      check("no_restart", Busy, 0);
    end
    run_div(8'd255, 8'd255, 1'b1, 0);
    run_div(8'd0, 8'd5, 1'b0, 0);
    run_div(8'd255, 8'd1, 1'b0, 0);
    run_div(8'd7, 8'd200, 1'b0, 0);
    run_div(8'h9C, 8'd7, 1'b0, 0);
    run_div(8'd100, 8'hF9, 1'b0, 0);
    run_div(8'h80, 8'd0, 1'b0, 0);

    // Abort 100/3 partway through SHIFT with Run still high.
    Dividend = 8'd100;
    Divisor  = 8'd3;
    Run      = 1'b1;
    repeat (5) tick();
    check("abort_busy_before", Busy, 1);
    Reset = 1'b0;
    tick();
    check("abort_quotient", Quotient, 0);
    check("abort_remainder", Remainder, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_dbz", DivByZero, 0);
    Reset = 1'b1;
    Run   = 1'b0;
    tick();
    check("abort_idle", Busy, 0);
    run_div(8'd100, 8'd3, 1'b0, 0);

    for (int i = 0; i < 20; i++)
      run_div(8'($urandom), 8'($urandom_range(0, 255)), 1'(i % 3 == 0), i % 2);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have port Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port Run  input  1  level start request, sampled on Clk.
REQ-005 SHALL have port Dividend  input  WIDTH  numerator, captured at start.
REQ-006 SHALL have port Divisor  input  WIDTH  denominator, captured at start.
REQ-007 SHALL have port Quotient  output  WIDTH  registered quotient.
REQ-008 SHALL have port Remainder  output  WIDTH  registered remainder.
REQ-009 SHALL have port Busy  output  1  high in LOAD and SHIFT states.
REQ-010 SHALL have port Done  output  1  high in DONE state only.
REQ-011 SHALL have port DivByZero  output  1  high with Done when captured Divisor was 0.

Function
REQ-012 SHALL implement restoring division over an internal (WIDTH+1)-bit partial remainder register A and WIDTH-bit quotient register Q, shifting left one bit per cycle (inverse of the shift-add multiplier datapath).
REQ-013 SHALL use FSM states IDLE, LOAD, SHIFT, DONE; IDLE->LOAD when Run=1; LOAD->SHIFT, or LOAD->DONE if captured Divisor=0; SHIFT->DONE after exactly WIDTH iterations; DONE->IDLE when Run=0.
REQ-014 SHALL in LOAD capture Dividend into Q, Divisor into internal register M, clear A, and load the iteration counter with WIDTH.
REQ-015 SHALL per SHIFT cycle: shift {A,Q} left by 1; if A-M is non-negative, set A=A-M and Q[0]=1, else keep A and set Q[0]=0; decrement counter.
REQ-016 SHALL update Quotient and Remainder only on the DONE-state entry edge; they hold prior values in all other states.
REQ-017 SHALL give latency of WIDTH+2 rising edges from Run sampled high in IDLE to Done high (10 for WIDTH=8); 2 edges for divide-by-zero.
REQ-018 SHALL on divide-by-zero set Quotient to all ones, Remainder to Dividend, and assert DivByZero.
REQ-019 SHALL ignore Dividend/Divisor changes after LOAD and Run changes during LOAD/SHIFT.
REQ-020 SHALL keep Done high while Run stays high in DONE (one result per Run pulse, no auto-restart).
REQ-021 SHALL accept a new Run rising in IDLE on the cycle immediately after DONE->IDLE.

Reset
REQ-022 SHALL, when Reset=0 at a rising Clk edge, force state IDLE, clear A, Q, M, counter, and drive Quotient=0, Remainder=0, Busy=0, Done=0, DivByZero=0.
REQ-023 SHALL abort any in-progress division on reset with no partial result visible on Quotient/Remainder.
REQ-024 SHALL have reset take priority over Run on the same edge.

Configuration
REQ-025 SHALL, with macro DIVIDER_SIGNED_EN defined, treat operands as two's complement: divide magnitudes, negate Quotient when operand signs differ, and give Remainder the sign of Dividend; latency unchanged.
REQ-026 SHALL, without DIVIDER_SIGNED_EN, treat operands as unsigned and contain no sign-handling logic.
REQ-027 SHALL apply REQ-018 in both modes (all-ones Quotient, Remainder = raw Dividend).

Verification
REQ-028 Unsigned 200/7, Run pulse -> after 10 edges Done=1, Quotient=28, Remainder=4, DivByZero=0.
REQ-029 Dividend=55, Divisor=0 -> Done after 2 edges, Quotient=0xFF, Remainder=55, DivByZero=1.
REQ-030 Run held high through DONE for 5 cycles, then low -> Done stays high for those 5 cycles, returns IDLE, no second computation.
REQ-031 Reset=0 asserted at iteration 4 of 100/3 -> next edge all outputs 0, state IDLE; a fresh 100/3 run then yields 33 r 1.
REQ-032 DIVIDER_SIGNED_EN: -100/7 -> Quotient=-14 (0xF2), Remainder=-2 (0xFE); 100/-7 -> -14, 2.
REQ-033 Operand inputs toggled randomly during SHIFT of 255/255 -> Quotient=1, Remainder=0.
